// File: rtl/serv_ls_pkg.sv
// serv_ls_pkg: shared encodings and lane-select helpers for the load/store sequencer.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package serv_ls_pkg;

    // Sequencer phases; IDLE must stay the all-zero encoding so reset lands there.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_INIT = 2'b01,
        ST_BUS  = 2'b10,
        ST_EXEC = 2'b11
    } state_e;

    // Access size as presented on i_size; 2'b11 is reserved and behaves as a word.
    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } size_e;

    // Cycles per serial phase (one per data bit).
    localparam int PHASE_LEN = 32;

    // Byte-lane enables for an access. Halves and words use the address
    // aligned down, so a misaligned request still produces a legal lane set.
    function automatic logic [3:0] lane_sel(input logic [1:0] size, input logic [1:0] lsb);
        logic [3:0] sel;
        case (size)
            SZ_BYTE: sel = 4'b0001 << lsb;
            SZ_HALF: sel = lsb[1] ? 4'b1100 : 4'b0011;
            default: sel = 4'b1111;
        endcase
        return sel;
    endfunction

    // True when the address cannot be served as a single naturally aligned access.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lsb);
        logic mis;
        case (size)
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = lsb[0];
            default: mis = (lsb != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/serv_ls_cnt.sv
// serv_ls_cnt: W_CNT-bit phase bit-counter with clear, enable, last flag and registered cnt0/cnt1 strobes.
// Latency: count and strobes update on the edge after clear/enable; o_last is combinational from the count.
// Backpressure: none; advances whenever enabled, wrapping from all-ones to zero.
module serv_ls_cnt #(
    parameter int W_CNT = 5
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    input  logic i_flag_en,
    output logic o_last,
    output logic o_cnt0,
    output logic o_cnt1
);

    logic [W_CNT-1:0] cnt_q;
    logic [W_CNT-1:0] cnt_d;
    logic             cnt0_q;
    logic             cnt0_d;
    logic             cnt1_q;
    logic             cnt1_d;

    // Next count, and strobes qualified by whether the next cycle is an active phase.
    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = '0;
        end else if (i_en) begin
            cnt_d = cnt_q + W_CNT'(1);
        end
        cnt0_d = i_flag_en && (cnt_d == '0);
        cnt1_d = i_flag_en && (cnt_d == W_CNT'(1));
    end

    // Count and strobe registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q  <= '0;
            cnt0_q <= 1'b0;
            cnt1_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign o_last = (cnt_q == {W_CNT{1'b1}});
    assign o_cnt0 = cnt0_q;
    assign o_cnt1 = cnt1_q;

endmodule

// File: rtl/serv_ls_seq.sv
// serv_ls_seq: bit-serial load/store sequencer (INIT -> BUS -> EXEC); SERV_LS_MISALIGN_TRAP_EN enables the misalignment trap.
// Latency: 32 INIT cycles after the request edge, BUS until ack, 32 EXEC cycles, o_done one cycle later.
// Backpressure: o_dbus_cyc is held with stable lanes until i_dbus_ack; i_ls_req is only taken while idle.
module serv_ls_seq
    import serv_ls_pkg::*;
#(
    parameter int W_CNT = 5
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_ls_req,
    input  logic       i_we,
    input  logic [1:0] i_size,
    input  logic [1:0] i_lsb,
    input  logic       i_dbus_ack,
    output logic       o_en,
    output logic       o_init,
    output logic       o_cnt0,
    output logic       o_cnt1,
    output logic       o_dbus_cyc,
    output logic       o_dbus_we,
    output logic [3:0] o_dbus_sel,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_misalign
);

    state_e     state_q;
    state_e     state_d;
    logic       we_q;
    logic       we_d;
    logic [1:0] size_q;
    logic [1:0] size_d;
    logic [3:0] sel_q;
    logic [3:0] sel_d;
    logic       en_q;
    logic       en_d;
    logic       init_q;
    logic       init_d;
    logic       cyc_q;
    logic       cyc_d;
    logic       dbus_we_q;
    logic       dbus_we_d;
    logic       busy_q;
    logic       busy_d;
    logic       done_q;
    logic       done_d;
    logic       mis_q;
    logic       mis_d;

    logic       cnt_clr;
    logic       cnt_en;
    logic       cnt_last;

    // The counter registers its own cnt0/cnt1 strobes, qualified by the next phase.
    serv_ls_cnt #(
        .W_CNT (W_CNT)
    ) u_cnt (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_clr     (cnt_clr),
        .i_en      (cnt_en),
        .i_flag_en (en_d),
        .o_last    (cnt_last),
        .o_cnt0    (o_cnt0),
        .o_cnt1    (o_cnt1)
    );

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, captured request fields, counter control and next-cycle output values.
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        size_d  = size_q;
        sel_d   = 4'b0000;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        done_d  = 1'b0;
        mis_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // Keep the counter parked at zero so INIT always starts from bit 0.
                cnt_clr = 1'b1;
                if (i_ls_req) begin
                    we_d    = i_we;
                    size_d  = i_size;
                    state_d = ST_INIT;
                end
            end
            ST_INIT: begin
                cnt_en = 1'b1;
                if (cnt_last) begin
`ifdef SERV_LS_MISALIGN_TRAP_EN
                    if (misaligned(size_q, i_lsb)) begin
                        state_d = ST_IDLE;
                        mis_d   = 1'b1;
                    end else begin
                        state_d = ST_BUS;
                        sel_d   = lane_sel(size_q, i_lsb);
                    end
`else
                    state_d = ST_BUS;
                    sel_d   = lane_sel(size_q, i_lsb);
`endif
                end
            end
            ST_BUS: begin
                // Lanes frozen for the whole bus cycle; restart the counter for EXEC on ack.
                if (i_dbus_ack) begin
                    cnt_clr = 1'b1;
                    state_d = ST_EXEC;
                end else begin
                    sel_d = sel_q;
                end
            end
            ST_EXEC: begin
                cnt_en = 1'b1;
                if (cnt_last) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
        endcase

        en_d      = (state_d == ST_INIT) || (state_d == ST_EXEC);
        init_d    = (state_d == ST_INIT);
        cyc_d     = (state_d == ST_BUS);
        dbus_we_d = cyc_d && we_d;
        busy_d    = (state_d != ST_IDLE);
    end

    // Captured request fields and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            we_q      <= 1'b0;
            size_q    <= 2'b00;
            sel_q     <= 4'b0000;
            en_q      <= 1'b0;
            init_q    <= 1'b0;
            cyc_q     <= 1'b0;
            dbus_we_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            mis_q     <= 1'b0;
        end else begin
            we_q      <= we_d;
            size_q    <= size_d;
            sel_q     <= sel_d;
            en_q      <= en_d;
            init_q    <= init_d;
            cyc_q     <= cyc_d;
            dbus_we_q <= dbus_we_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            mis_q     <= mis_d;
        end
    end

    assign o_en       = en_q;
    assign o_init     = init_q;
    assign o_dbus_cyc = cyc_q;
    assign o_dbus_we  = dbus_we_q;
    assign o_dbus_sel = sel_q;
    assign o_busy     = busy_q;
    assign o_done     = done_q;
    assign o_misalign = mis_q;

endmodule

// File: doc/serv_ls_seq.md
SERV_LS_SEQ -- requirements
Module: serv_ls_seq

Interface
REQ-001 Parameter W_CNT, default 5, SHALL set the bit-counter width; a phase lasts 2^W_CNT cycles (32).
REQ-002 i_clk  in  1  single clock; all state changes on its rising edge.
REQ-003 i_rst  in  1  reset, synchronous, active-high.
REQ-004 i_ls_req  in  1  start a load/store; sampled only in IDLE.
REQ-005 i_we  in  1  1 = store, 0 = load; captured with i_ls_req.
REQ-006 i_size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word); captured with i_ls_req.
REQ-007 i_lsb  in  2  address bits [1:0] from the buffer register.
REQ-008 i_dbus_ack  in  1  data-bus acknowledge.
REQ-009 o_en, o_init, o_cnt0, o_cnt1  out  1 each  buffer-register sequencing strobes.
REQ-010 o_dbus_cyc, o_dbus_we  out  1 each  bus cycle request and direction.
REQ-011 o_dbus_sel  out  4  byte-lane select.
REQ-012 o_busy, o_done, o_misalign  out  1 each  status; o_done and o_misalign are one-cycle pulses.

Function
REQ-013 States: IDLE, INIT, BUS and EXEC; all outputs registered.
REQ-014 IDLE and i_ls_req=1 SHALL capture i_we and i_size, clear the counter and enter INIT on the next edge; i_ls_req SHALL be ignored in all other states.
REQ-015 INIT SHALL drive o_en=1 and o_init=1 for exactly 32 cycles, counter values 0..31.
REQ-016 o_cnt0 SHALL be 1 when counter=0 and o_cnt1 when counter=1, only in INIT or EXEC; both 0 elsewhere.
REQ-017 INIT at counter=31 SHALL compute o_dbus_sel from i_size and i_lsb sampled that cycle, then enter BUS.
REQ-018 Lane select: byte = 1 shifted left by lsb; half = 1100 if lsb[1] else 0011; word = 1111.
REQ-019 BUS SHALL hold o_dbus_cyc=1, o_dbus_we=captured i_we, o_en=0 and a stable o_dbus_sel until i_dbus_ack=1; EXEC is entered on the next edge.
REQ-020 i_dbus_ack SHALL be ignored outside BUS; ack on the first BUS cycle is legal.
REQ-021 EXEC SHALL drive o_en=1 and o_init=0 for exactly 32 cycles, with the counter restarting at 0.
REQ-022 After EXEC counter=31 the block SHALL return to IDLE with o_done=1 for one cycle.
REQ-023 o_busy SHALL be 1 in INIT, BUS and EXEC.
REQ-024 The counter SHALL wrap 31->0 and is unused in IDLE and BUS.
REQ-025 Latency: request at edge N gives INIT N+1..N+32, BUS from N+33; ack at edge M gives EXEC M+1..M+32 and o_done at M+33.
REQ-026 A new i_ls_req is accepted in the cycle o_done is high.

Reset
REQ-027 i_rst=1 SHALL force IDLE, counter 0 and every output 0 on the next edge, including mid-phase and with o_dbus_cyc high; no o_done is generated for the aborted access.

Configuration
REQ-028 With SERV_LS_MISALIGN_TRAP_EN defined, at the end of INIT a half access with lsb[0]=1 or a word access with lsb!=00 SHALL skip BUS and EXEC, return to IDLE and pulse o_misalign for one cycle, with no o_done.
REQ-029 Without SERV_LS_MISALIGN_TRAP_EN, o_misalign SHALL be constant 0 and lane select SHALL use the address aligned down (half ignores lsb[0]; word ignores lsb).

Structure
REQ-030 Package serv_ls_pkg SHALL hold the state encoding, the size encodings (BYTE/HALF/WORD) and the constant PHASE_LEN=32.
REQ-031 A sub-module serv_ls_cnt (W_CNT-bit counter with clear, enable, last and cnt0/cnt1 flags) is the only natural split.

Verification
REQ-032 Word load at lsb=00 with ack 3 cycles after BUS entry -> 32 INIT cycles, sel=1111, we=0, cyc for 3 cycles, 32 EXEC cycles, then one o_done.
REQ-033 Byte store at lsb=10 with ack on the first BUS cycle -> sel=0100, we=1, o_done exactly 66 cycles after the request edge.
REQ-034 Half load at lsb=01 -> with the macro: o_misalign pulse, cyc never asserted; without it: sel=0011 and normal completion.
REQ-035 i_rst asserted in BUS with cyc=1 -> next cycle all outputs 0, IDLE, no o_done; a later request completes normally.
REQ-036 Back-to-back requests with i_ls_req held high -> second INIT starts the cycle after o_done; o_cnt0 high on the first cycle of each phase only.
